// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, drives the instruction-memory address and registers each
// returned word with its PC. Supports decode stall, redirect with one bubble, and halt.
module instr_fetch #(
  parameter int unsigned   n         = 32,
  parameter int unsigned   r         = 7,
  parameter logic [n-1:0]  HALT_WORD = {n{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [r-1:0]  readAddr,
  input  logic [n-1:0]  instr,
  input  logic          stall,
  input  logic          redirect,
  input  logic [r-1:0]  target,
  output logic          outValid,
  output logic [n-1:0]  outInstr,
  output logic [r-1:0]  outPC,
  output logic          halted,
  output logic [15:0]   fetchCount
);

  typedef enum logic {StFetch, StHalt} state_e;

  state_e       state;
  logic [r-1:0] pc;

  assign readAddr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      state      <= StFetch;
      outValid   <= 1'b0;
      outInstr   <= '0;
      outPC      <= '0;
      halted     <= 1'b0;
      fetchCount <= '0;
    end else if (redirect) begin
      // The word currently on instr is discarded; outPC keeps its last value.
      pc       <= target;
      state    <= StFetch;
      outValid <= 1'b0;
      outInstr <= '0;
      halted   <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        StFetch: begin
          outInstr <= instr;
          outPC    <= pc;
          outValid <= 1'b1;
          if (fetchCount != 16'hFFFF) begin
            fetchCount <= fetchCount + 16'd1;
          end
          if (instr == HALT_WORD) begin
            // PC parks on the halt address until a redirect or reset.
            state  <= StHalt;
            halted <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        StHalt: begin
          outValid <= 1'b0;
        end
        default: begin
          state <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly upstream of the word-aligned instruction memory. Holds the program counter, drives the memory read address, and registers each returned instruction with its PC into the fetch/decode boundary. Supports decode-side stall, branch/jump redirect with a one-cycle flush bubble, and a halt state entered on a reserved halt word.

## Interface

Parameters:
- `n`, 32: instruction width in bits.
- `r`, 7: word-address width; instruction memory depth is 2**r words.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch. Width is `n`.

Ports:
- `clk`  input  1  single clock. All state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `readAddr`  output  r  word address to instruction memory; equals `pc`.
- `instr`  input  n  instruction word returned combinationally by instruction memory for `readAddr`.
- `stall`  input  1  decode cannot accept; hold PC and all registered outputs.
- `redirect`  input  1  taken branch/jump; load `target` into PC.
- `target`  input  r  redirect word address.
- `outValid`  output  1  `outInstr`/`outPC` carry a real instruction.
- `outInstr`  output  n  registered instruction.
- `outPC`  output  r  word address `outInstr` was fetched from.
- `halted`  output  1  high while in HALT.
- `fetchCount`  output  16  number of instructions delivered with `outValid`=1; saturating.

## Operation

- State: `pc` (r bits), FSM {FETCH, HALT}, output registers, `fetchCount`.
- Reset (`rst_n`=0 at an edge): `pc`=0, state=FETCH, `outValid`=0, `outInstr`=0, `outPC`=0, `halted`=0, `fetchCount`=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- Edge priority, highest first: reset, redirect, stall, normal.
- Redirect, in either state: `pc`<=`target`, `outValid`<=0, `outInstr`<=0, state<=FETCH, `halted`<=0. `stall` is ignored that cycle. The instruction currently on `instr` is discarded.
- Stall, with no redirect: `pc`, state and all outputs hold. `fetchCount` holds.
- FETCH, normal: `outInstr`<=`instr`, `outPC`<=`pc`, `outValid`<=1, `pc`<=`pc`+1 modulo 2**r, so 2**r-1 wraps to 0. `fetchCount`<=`fetchCount`+1 and saturates at 16'hFFFF.
- FETCH, normal, with `instr`==`HALT_WORD`: the halt word is delivered as above with `outValid`<=1 and counted. `pc` holds at the halt address. State<=HALT and `halted`<=1.
- HALT, normal: `outValid`<=0. `outInstr` and `outPC` hold the halt word and its address. `pc` holds. Only redirect or reset leaves HALT.
- HALT, stall: everything holds, including `outValid`.

## Timing

- `readAddr` is a combinational copy of `pc`. Memory read is combinational, so fetch-to-`outInstr` latency is 1 cycle.
- Throughput with no stall: 1 instruction per cycle.
- Redirect cost: 1 bubble. At the redirect edge `outValid`=0. At the next edge, `outInstr`=mem[`target`] and `outPC`=`target`.
- First instruction after reset release: `outInstr`=mem[0] at the first edge with `rst_n`=1.
- `halted` rises at the same edge that registers the halt word. `outValid` falls one non-stalled edge later.
- No combinational path from any input to any output except `readAddr`, which has no input dependence.

## Test plan

- Reset then run with mem[0..3] = A, B, C, D and no stall: at edges 1..4, `outInstr`=A, B, C, D; `outPC`=0, 1, 2, 3; `outValid`=1; then `fetchCount`=4.
- Stall held for 3 cycles after B is delivered: `outInstr`=B, `outPC`=1 and `readAddr`=2 are unchanged for 3 cycles. C follows on the first unstalled edge and `fetchCount` does not advance during the stall.
- Redirect with `target`=7'h40 asserted together with `stall`=1 while `pc`=5: at the next edge `outValid`=0 and `readAddr`=7'h40. One edge later `outInstr`=mem[0x40] and `outPC`=7'h40.
- Wrap-around, using redirect to 7'h7F with mem[0x7F]=E and mem[0]=A: `outInstr` delivers E with `outPC`=7'h7F, then A with `outPC`=0.
- Halt with mem[2]=32'hFFFF_FFFF: the halt word is delivered with `outValid`=1 and `halted`=1. Next edge `outValid`=0, `readAddr` stays 2, and `fetchCount`=3 permanently. A later redirect to 0 clears `halted` and resumes fetch from A.
- Reset asserted mid-stream while stalled and after a redirect: at that edge all outputs return to reset values and `readAddr`=0. `fetchCount` saturation is checked by preloading 16'hFFFF through a long run and confirming it stays at 16'hFFFF.
